// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared FSM state type and width defaults for the shift-register sequencer.
package shift_reg_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
   localparam int REG_WIDTH_DEF = 8;
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/shift_reg.sv
// shift_reg: parallel-load shift register with zero fill and a registered shifted-out bit.
module shift_reg
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             shift_en_i,
   input  logic             left_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] q_o,
   output logic             serial_o
);
   logic [WIDTH-1:0] q_q, q_d;
   logic             ser_q, ser_d;
   logic             shifting;
   assign shifting = shift_en_i && !load_i;
   always_comb begin
      q_d   = load_i ? data_i
            : shifting ? (left_i ? {q_q[WIDTH-2:0], 1'b0} : {1'b0, q_q[WIDTH-1:1]})
            : q_q;
      ser_d = shifting ? (left_i ? q_q[WIDTH-1] : q_q[0]) : ser_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q   <= '0;
         ser_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ser_q <= ser_d;
      end
   end
   assign q_o      = q_q;
   assign serial_o = ser_q;
endmodule

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: accepts load-and-shift jobs and steps shift_reg through LOAD, SHIFT and DONE.
module shift_reg_sequencer
   import shift_reg_pkg::*;
#(
   parameter int REG_WIDTH = REG_WIDTH_DEF,
   parameter int CNT_W     = cnt_width(REG_WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_start,
   output logic                 o_ready,
   input  logic [REG_WIDTH-1:0] i_data_in,
   input  logic                 i_shift_left_right,
   input  logic [CNT_W-1:0]     i_shift_count,
   input  logic                 i_abort,
   output logic [REG_WIDTH-1:0] o_q,
   output logic                 o_serial_out,
   output logic                 o_busy,
   output logic                 o_done
);
   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q, cnt_clamp;
   logic [REG_WIDTH-1:0] data_q;
   logic                 dir_q, done_q, busy_q, ready_q;
   logic                 load, shift_en;
   assign cnt_clamp = (i_shift_count > CNT_W'(REG_WIDTH)) ? CNT_W'(REG_WIDTH) : i_shift_count;
   // Abort suppresses any register activity on the edge it is seen.
   assign load     = (state_q == LOAD) && !i_abort;
   assign shift_en = (state_q == SHIFT) && !i_abort;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (i_start) begin
               state_q <= LOAD;
               data_q  <= i_data_in;
               dir_q   <= i_shift_left_right;
               cnt_q   <= cnt_clamp;
               busy_q  <= 1'b1;
               ready_q <= 1'b0;
            end
            LOAD: if (i_abort) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end else if (cnt_q == '0) begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               state_q <= SHIFT;
            end
            SHIFT: if (i_abort) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end
   shift_reg #(.WIDTH(REG_WIDTH)) u_shift_reg (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load),
      .shift_en_i (shift_en),
      .left_i     (dir_q),
      .data_i     (data_q),
      .q_o        (o_q),
      .serial_o   (o_serial_out)
   );
   assign o_done  = done_q;
   assign o_busy  = busy_q;
   assign o_ready = ready_q;
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: directed jobs with hand-computed register contents and handshake timing.
module tb_shift_reg_sequencer;
   localparam int W  = 8;
   localparam int CW = 4;
   logic          clk = 1'b0;
   logic          reset, i_start, i_shift_left_right, i_abort;
   logic          o_ready, o_serial_out, o_busy, o_done;
   logic [W-1:0]  i_data_in, o_q;
   logic [CW-1:0] i_shift_count;
   int            compared = 0;
   int            mismatched = 0;
   always #5 clk = ~clk;
   shift_reg_sequencer #(.REG_WIDTH(W), .CNT_W(CW)) dut (
      .clk                (clk),
      .reset              (reset),
      .i_start            (i_start),
      .o_ready            (o_ready),
      .i_data_in          (i_data_in),
      .i_shift_left_right (i_shift_left_right),
      .i_shift_count      (i_shift_count),
      .i_abort            (i_abort),
      .o_q                (o_q),
      .o_serial_out       (o_serial_out),
      .o_busy             (o_busy),
      .o_done             (o_done)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic ctl(input string tag, input logic rdy, input logic bsy, input logic dn);
      chk({tag, "_ready"}, {7'd0, o_ready}, {7'd0, rdy});
      chk({tag, "_busy"},  {7'd0, o_busy},  {7'd0, bsy});
      chk({tag, "_done"},  {7'd0, o_done},  {7'd0, dn});
   endtask
   task automatic start_job(input logic [W-1:0] d, input logic left, input logic [CW-1:0] n);
      i_data_in = d;
      i_shift_left_right = left;
      i_shift_count = n;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask
   initial begin
      reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
      i_data_in = '0; i_shift_left_right = 1'b0; i_shift_count = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_q", o_q, 8'h00);
      chk("rst_ser", {7'd0, o_serial_out}, 8'h00);
      ctl("rst", 1'b1, 1'b0, 1'b0);
      // A5 left by 3: 4A/1, 94/0, 28/1
      start_job(8'hA5, 1'b1, 4'd3);
      ctl("t1_load", 1'b0, 1'b1, 1'b0);
      step();
      chk("t1_loaded", o_q, 8'hA5);
      step();
      chk("t1_q1", o_q, 8'h4A); chk("t1_s1", {7'd0, o_serial_out}, 8'h01);
      step();
      chk("t1_q2", o_q, 8'h94); chk("t1_s2", {7'd0, o_serial_out}, 8'h00);
      ctl("t1_mid", 1'b0, 1'b1, 1'b0);
      step();
      chk("t1_q3", o_q, 8'h28); chk("t1_s3", {7'd0, o_serial_out}, 8'h01);
      ctl("t1_c5", 1'b0, 1'b0, 1'b1);
      step();
      ctl("t1_idle", 1'b1, 1'b0, 1'b0);
      chk("t1_hold", o_q, 8'h28);
      // count 0: load only, serial keeps the 1 left by the previous job
      start_job(8'hA5, 1'b1, 4'd0);
      ctl("t3_c1", 1'b0, 1'b1, 1'b0);
      step();
      ctl("t3_c2", 1'b0, 1'b0, 1'b1);
      chk("t3_q", o_q, 8'hA5); chk("t3_ser", {7'd0, o_serial_out}, 8'h01);
      step();
      ctl("t3_idle", 1'b1, 1'b0, 1'b0);
      // 01 right by 2
      start_job(8'h01, 1'b0, 4'd2);
      step(); step();
      chk("t2_q1", o_q, 8'h00); chk("t2_s1", {7'd0, o_serial_out}, 8'h01);
      step();
      chk("t2_q2", o_q, 8'h00); chk("t2_s2", {7'd0, o_serial_out}, 8'h00);
      ctl("t2_c4", 1'b0, 1'b0, 1'b1);
      step();
      ctl("t2_after", 1'b1, 1'b0, 1'b0);
      // count 12 clamps to 8: done in cycle 10
      start_job(8'hFF, 1'b1, 4'd12);
      for (int i = 2; i <= 9; i++) begin
         step();
         chk($sformatf("t4_nodone_c%0d", i), {7'd0, o_done}, 8'h00);
      end
      step();
      ctl("t4_c10", 1'b0, 1'b0, 1'b1);
      chk("t4_q", o_q, 8'h00); chk("t4_ser", {7'd0, o_serial_out}, 8'h01);
      step();
      // abort on the 2nd SHIFT cycle of a count-5 job; start during SHIFT ignored
      start_job(8'h81, 1'b1, 4'd5);
      step();
      chk("t5_loaded", o_q, 8'h81);
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("t5_q1", o_q, 8'h02); chk("t5_s1", {7'd0, o_serial_out}, 8'h01);
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      ctl("t5_abort", 1'b1, 1'b0, 1'b0);
      chk("t5_hold", o_q, 8'h02); chk("t5_shold", {7'd0, o_serial_out}, 8'h01);
      step();
      ctl("t5_noqueue", 1'b1, 1'b0, 1'b0);
      chk("t5_hold2", o_q, 8'h02);
      // reset in the middle of a shift job
      start_job(8'hF0, 1'b0, 4'd4);
      step(); step();
      chk("t6_q1", o_q, 8'h78);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_q", o_q, 8'h00); chk("t6_ser", {7'd0, o_serial_out}, 8'h00);
      ctl("t6_rst", 1'b1, 1'b0, 1'b0);
      step();
      ctl("t6_nodone", 1'b1, 1'b0, 1'b0);
      start_job(8'hC3, 1'b1, 4'd1);
      step(); step();
      chk("t6_newq", o_q, 8'h86); chk("t6_newser", {7'd0, o_serial_out}, 8'h01);
      ctl("t6_newdone", 1'b0, 1'b0, 1'b1);
      step();
      ctl("t6_end", 1'b1, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
